circular_step_walker: RTL and testbench
=======================================

Name: circular_step_walker

Overview:
- Downstream consumer of the circular op's step-count calculator. Walks a circular arc one unit axis step at a time, starting from a start point relative to the centre.
- Each step is the single X or Y move that keeps the point closest to the circle (incremental midpoint error).
- Emits exactly num_steps steps through a valid/ready handshake to the motor/step-queue stage.
- Feeds the motor stage inside the circular op handler.

Parameters:
- NUM_BITS, `BYTE_BITS: width of signed coordinates and radius; must match the upstream calculator.
- STEP_BITS, NUM_BITS+3: width of num_steps (localparam).
- ERR_BITS, 2*NUM_BITS+3: width of the signed error register (localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  accept a job when rdy=1.
- is_cw  in  1  clockwise walk.
- start_x  in  NUM_BITS  signed start X relative to centre.
- start_y  in  NUM_BITS  signed start Y relative to centre.
- r  in  NUM_BITS  radius, positive.
- num_steps  in  STEP_BITS  step count from the upstream calculator.
- rdy  out  1  idle, can accept start.
- step_valid  out  1  step_x/step_y hold a valid step.
- step_ready  in  1  consumer accepts the step.
- step_x  out  2  StepDir_t for the X axis.
- step_y  out  2  StepDir_t for the Y axis.
- cur_x  out  NUM_BITS  current relative X (before the presented step).
- cur_y  out  NUM_BITS  current relative Y.
- done  out  1  one-cycle pulse after the last step is accepted.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, rdy=1, step_valid=0, done=0, step_x=step_y=STEP_NONE, cur_x=cur_y=0, counter=0, err=0. Reset overrides everything, including mid-walk; any in-flight step is dropped.
- IDLE: start=1 latches all inputs, drops rdy, goes to INIT. start while not rdy is ignored.
- INIT (1 cycle):
  - err = start_x^2 + start_y^2 - r^2, signed ERR_BITS.
  - cnt = num_steps.
  - If num_steps==0, go to DONE; else go to STEP.
  - The multiply is used only here.
- STEP: step_valid=1 from the first STEP cycle, i.e. 2 cycles after start was accepted.
  - Candidate directions (CCW): dxs = NEG if y>=0 else POS; dys = POS if x>=0 else NEG. For CW, invert both.
  - errX = err + 2*x*sx + 1 and errY = err + 2*y*sy + 1, where sx/sy = ±1.
  - Choose the X step if |errX| <= |errY| (ties go to X); otherwise the Y step. Exactly one axis is non-NONE per step.
  - step_x/step_y/cur_x/cur_y are combinationally derived from registered state and stay stable while step_valid=1 and step_ready=0.
  - On step_valid & step_ready: update x/y and err to the chosen candidate, cnt-=1. If cnt reaches 0, go to DONE; else remain in STEP.
  - Back-to-back steps are allowed: 1 step per cycle with step_ready held high.
- DONE (1 cycle): done=1, step_valid=0, then go to IDLE with rdy=1.
- Arithmetic and widths:
  - All arithmetic is signed.
  - Coordinates never leave [-r, r]; no saturation logic.
  - err width is sufficient for NUM_BITS=8 without overflow.
- Non-zero start error (start point off the circle) is allowed; the walk converges toward the circle.

Decomposition:
- New package Circular_PKG holds:
  - StepDir_t: 2-bit enum, STEP_NONE=2'b00, STEP_POS=2'b01, STEP_NEG=2'b11.
  - WalkerState_t: IDLE, INIT, STEP, DONE.
- Reuse Position_PKG for anything quadrant-related; no new quadrant types.
- One sub-module: circular_step_walker_chooser (combinational). Inputs x, y, err, is_cw; outputs chosen step_x, step_y and next err.

Test Plan:
- r=4, start (4,0), CCW, num_steps=8, step_ready=1:
  - Steps Y+,Y+,X-,Y+,X-,Y+,X-,X-.
  - cur ends at (0,4).
  - done exactly 1 cycle after the 8th handshake.
  - First step_valid 2 cycles after start.
- r=4, start (4,0), CW, num_steps=32: returns to (4,0) with 32 steps; every step has exactly one non-NONE axis; done pulses once.
- Backpressure: same as case 1 but step_ready low for 3 cycles at step 3. step_x=NEG, cur=(4,2) held stable; total cycle count is 3 more than case 1.
- num_steps=0: no step_valid; done pulses on the cycle after INIT; rdy returns the next cycle.
- start asserted while walking: ignored, job completes unchanged. reset=0 at step 5: next cycle step_valid=0, rdy=1, cur=(0,0); a new job then runs normally.
- r=3, start (0,-3), CCW, num_steps=6: first step X+ (tie rule not triggered; |errX|=1 < |errY|=5); ends at (3,0).

Source files
------------

// File: rtl/circular_step_walker_pkg.sv
// Shared types for the circular-op step walker: per-axis step encoding and walker FSM states.
package Circular_PKG;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_POS  = 2'b01,
    STEP_NEG  = 2'b11
  } StepDir_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    STEP,
    DONE
  } WalkerState_t;

endpackage

// File: rtl/circular_step_walker_chooser.sv
// Picks the single X or Y unit step that keeps the point closest to the circle,
// and returns the midpoint error after taking it.
module circular_step_walker_chooser
  import Circular_PKG::*;
#(
  parameter int NUM_BITS = BYTE_BITS,
  parameter int ERR_BITS = 2 * NUM_BITS + 3
) (
  input  logic signed [NUM_BITS-1:0] x,
  input  logic signed [NUM_BITS-1:0] y,
  input  logic signed [ERR_BITS-1:0] err,
  input  logic                       is_cw,
  output StepDir_t                   step_x,
  output StepDir_t                   step_y,
  output logic signed [ERR_BITS-1:0] err_next
);

  localparam logic signed [ERR_BITS-1:0] ONE_E = ERR_BITS'(1);

  logic                       x_neg;
  logic                       y_neg;
  logic signed [ERR_BITS-1:0] x_e;
  logic signed [ERR_BITS-1:0] y_e;
  logic signed [ERR_BITS-1:0] err_x;
  logic signed [ERR_BITS-1:0] err_y;
  logic        [ERR_BITS-1:0] abs_x;
  logic        [ERR_BITS-1:0] abs_y;
  logic                       take_x;

  always_comb begin
    // CCW tangent: X moves against the sign of y, Y moves with the sign of x.
    x_neg = (y >= 0);
    y_neg = (x < 0);
    if (is_cw) begin
      x_neg = ~x_neg;
      y_neg = ~y_neg;
    end

    x_e = {{(ERR_BITS-NUM_BITS){x[NUM_BITS-1]}}, x};
    y_e = {{(ERR_BITS-NUM_BITS){y[NUM_BITS-1]}}, y};

    err_x = x_neg ? (err - (x_e <<< 1) + ONE_E) : (err + (x_e <<< 1) + ONE_E);
    err_y = y_neg ? (err - (y_e <<< 1) + ONE_E) : (err + (y_e <<< 1) + ONE_E);

    abs_x = err_x[ERR_BITS-1] ? ERR_BITS'(-err_x) : ERR_BITS'(err_x);
    abs_y = err_y[ERR_BITS-1] ? ERR_BITS'(-err_y) : ERR_BITS'(err_y);

    take_x = (abs_x <= abs_y);

    step_x   = STEP_NONE;
    step_y   = STEP_NONE;
    err_next = err_y;
    if (take_x) begin
      step_x   = x_neg ? STEP_NEG : STEP_POS;
      err_next = err_x;
    end else begin
      step_y   = y_neg ? STEP_NEG : STEP_POS;
    end
  end

endmodule

// File: rtl/circular_step_walker.sv
// Walks a circular arc one axis step at a time from a start point relative to the
// centre, emitting exactly num_steps steps over a valid/ready handshake.
module circular_step_walker
  import Circular_PKG::*;
#(
  parameter  int NUM_BITS  = BYTE_BITS,
  localparam int STEP_BITS = NUM_BITS + 3,
  localparam int ERR_BITS  = 2 * NUM_BITS + 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        is_cw,
  input  logic signed [NUM_BITS-1:0]  start_x,
  input  logic signed [NUM_BITS-1:0]  start_y,
  input  logic signed [NUM_BITS-1:0]  r,
  input  logic        [STEP_BITS-1:0] num_steps,
  output logic                        rdy,
  output logic                        step_valid,
  input  logic                        step_ready,
  output StepDir_t                    step_x,
  output StepDir_t                    step_y,
  output logic signed [NUM_BITS-1:0]  cur_x,
  output logic signed [NUM_BITS-1:0]  cur_y,
  output logic                        done
);

  localparam logic signed [NUM_BITS-1:0] ONE_N = NUM_BITS'(1);
  localparam logic [STEP_BITS-1:0]       ONE_S = STEP_BITS'(1);

  WalkerState_t               state;
  logic signed [NUM_BITS-1:0] x_q;
  logic signed [NUM_BITS-1:0] y_q;
  logic signed [NUM_BITS-1:0] r_q;
  logic                       cw_q;
  logic [STEP_BITS-1:0]       cnt_q;
  logic signed [ERR_BITS-1:0] err_q;

  logic signed [ERR_BITS-1:0] x_e;
  logic signed [ERR_BITS-1:0] y_e;
  logic signed [ERR_BITS-1:0] r_e;
  StepDir_t                   ch_step_x;
  StepDir_t                   ch_step_y;
  logic signed [ERR_BITS-1:0] ch_err;

  always_comb begin
    x_e = {{(ERR_BITS-NUM_BITS){x_q[NUM_BITS-1]}}, x_q};
    y_e = {{(ERR_BITS-NUM_BITS){y_q[NUM_BITS-1]}}, y_q};
    r_e = {{(ERR_BITS-NUM_BITS){r_q[NUM_BITS-1]}}, r_q};
  end

  circular_step_walker_chooser #(
    .NUM_BITS (NUM_BITS),
    .ERR_BITS (ERR_BITS)
  ) u_chooser (
    .x        (x_q),
    .y        (y_q),
    .err      (err_q),
    .is_cw    (cw_q),
    .step_x   (ch_step_x),
    .step_y   (ch_step_y),
    .err_next (ch_err)
  );

  assign cur_x  = x_q;
  assign cur_y  = y_q;
  // Chooser output is meaningless outside STEP, so mask it to NONE.
  assign step_x = step_valid ? ch_step_x : STEP_NONE;
  assign step_y = step_valid ? ch_step_y : STEP_NONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rdy        <= 1'b1;
      step_valid <= 1'b0;
      done       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      cw_q       <= 1'b0;
      cnt_q      <= '0;
      err_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q   <= start_x;
            y_q   <= start_y;
            r_q   <= r;
            cw_q  <= is_cw;
            cnt_q <= num_steps;
            rdy   <= 1'b0;
            state <= INIT;
          end
        end
        INIT: begin
          err_q <= x_e * x_e + y_e * y_e - r_e * r_e;
          if (cnt_q == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            step_valid <= 1'b1;
            state      <= STEP;
          end
        end
        STEP: begin
          if (step_ready) begin
            case (ch_step_x)
              STEP_POS: x_q <= x_q + ONE_N;
              STEP_NEG: x_q <= x_q - ONE_N;
              default:  ;
            endcase
            case (ch_step_y)
              STEP_POS: y_q <= y_q + ONE_N;
              STEP_NEG: y_q <= y_q - ONE_N;
              default:  ;
            endcase
            err_q <= ch_err;
            cnt_q <= cnt_q - ONE_S;
            if (cnt_q == ONE_S) begin
              step_valid <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circular_step_walker.sv
// Directed, table-driven bench for circular_step_walker with an independent
// squared-distance model of the step choice.
module tb_circular_step_walker;
  import Circular_PKG::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              is_cw = 1'b0;
  logic signed [7:0] start_x = '0;
  logic signed [7:0] start_y = '0;
  logic signed [7:0] r = '0;
  logic [10:0]       num_steps = '0;
  logic              rdy;
  logic              step_valid;
  logic              step_ready = 1'b0;
  StepDir_t          step_x;
  StepDir_t          step_y;
  logic signed [7:0] cur_x;
  logic signed [7:0] cur_y;
  logic              done;

  int tests = 0;
  int fails = 0;
  int step_log[64];

  circular_step_walker #(.NUM_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_cw      (is_cw),
    .start_x    (start_x),
    .start_y    (start_y),
    .r          (r),
    .num_steps  (num_steps),
    .rdy        (rdy),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_x     (step_x),
    .step_y     (step_y),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int dir2int(input logic [1:0] d);
    case (d)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 9;
    endcase
  endfunction

  // Pick the axis step whose resulting point has the smaller |x^2+y^2-r^2|.
  function automatic void model(input int x, input int y, input int rr, input bit cw,
                                output int ex, output int ey);
    int sx, sy, ea, eb;
    sx = (y >= 0) ? -1 : 1;
    sy = (x >= 0) ? 1 : -1;
    if (cw) begin
      sx = -sx;
      sy = -sy;
    end
    ea = (x + sx) * (x + sx) + y * y - rr * rr;
    eb = x * x + (y + sy) * (y + sy) - rr * rr;
    if (ea < 0) ea = -ea;
    if (eb < 0) eb = -eb;
    if (ea <= eb) begin
      ex = sx;
      ey = 0;
    end else begin
      ex = 0;
      ey = sy;
    end
  endfunction

  typedef struct {
    bit cw;
    int sx, sy, rr, n;
    int stall_at, stall_len;
    bit poke;
    int exp_x, exp_y, exp_cycles;
  } vec_t;

  task automatic run_job(input vec_t v);
    int mx, my, ex, ey, hs, stall, guard, first_valid, last_hs, cycles, done_cycle;
    bit seen_done;
    guard = 0;
    while (!rdy && guard < 50) begin
      tick();
      guard++;
    end
    check("rdy_before_start", int'(rdy), 1);
    is_cw      = v.cw;
    start_x    = 8'(v.sx);
    start_y    = 8'(v.sy);
    r          = 8'(v.rr);
    num_steps  = 11'(v.n);
    step_ready = 1'b0;
    start      = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    check("rdy_after_accept", int'(rdy), 0);
    mx = v.sx; my = v.sy; hs = 0; stall = 0;
    first_valid = -1; last_hs = -1; done_cycle = -1; seen_done = 0;
    while (!seen_done && cycles < 300) begin
      if (done) begin
        seen_done  = 1;
        done_cycle = cycles;
      end else begin
        step_ready = (hs == v.stall_at && stall < v.stall_len) ? 1'b0 : 1'b1;
        start      = v.poke && (hs == 1);
        if (step_valid) begin
          if (first_valid < 0) first_valid = cycles;
          model(mx, my, v.rr, v.cw, ex, ey);
          check("step_x", dir2int(step_x), ex);
          check("step_y", dir2int(step_y), ey);
          check("cur_x", int'(cur_x), mx);
          check("cur_y", int'(cur_y), my);
          if (step_ready) begin
            step_log[hs] = ex + 2 * ey;
            mx += ex;
            my += ey;
            hs++;
            last_hs = cycles;
          end else begin
            stall++;
            if (v.stall_at == 2) begin
              check("stall_step_x", dir2int(step_x), -1);
              check("stall_cur_x", int'(cur_x), 4);
              check("stall_cur_y", int'(cur_y), 2);
            end
          end
        end
        tick();
        cycles++;
      end
    end
    start = 1'b0;
    check("done_seen", int'(seen_done), 1);
    check("handshakes", hs, v.n);
    check("first_valid_cycle", first_valid, (v.n == 0) ? -1 : 2);
    if (v.n > 0) check("done_after_last", done_cycle, last_hs + 1);
    check("done_cycle", done_cycle, v.exp_cycles);
    check("valid_in_done", int'(step_valid), 0);
    check("end_x", int'(cur_x), v.exp_x);
    check("end_y", int'(cur_y), v.exp_y);
    tick();
    check("done_one_pulse", int'(done), 0);
    check("rdy_after_done", int'(rdy), 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   exp_seq[8];
    int   guard;

    vecs[0] = '{0, 4, 0, 4, 8, -1, 0, 0, 0, 4, 10};
    vecs[1] = '{1, 4, 0, 4, 32, -1, 0, 0, 4, 0, 34};
    vecs[2] = '{0, 4, 0, 4, 8, 2, 3, 0, 0, 4, 13};
    vecs[3] = '{0, 4, 0, 4, 0, -1, 0, 0, 4, 0, 2};
    vecs[4] = '{0, 4, 0, 4, 8, -1, 0, 1, 0, 4, 10};
    vecs[5] = '{0, 0, -3, 3, 6, -1, 0, 0, 3, 0, 8};
    vecs[6] = '{0, 3, 3, 5, 4, -1, 0, 0, 1, 5, 6};
    // Y+ = 2, X- = -1
    exp_seq = '{2, 2, -1, 2, -1, 2, -1, -1};

    reset = 1'b0;
    tick();
    tick();
    check("rst_rdy", int'(rdy), 1);
    check("rst_valid", int'(step_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_step_x", dir2int(step_x), 0);
    check("rst_step_y", dir2int(step_y), 0);
    check("rst_cur_x", int'(cur_x), 0);
    check("rst_cur_y", int'(cur_y), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i]);
      if (i == 0) begin
        for (int k = 0; k < 8; k++) check("ccw_seq", step_log[k], exp_seq[k]);
      end
      if (i == 5) check("r3_first_step", step_log[0], 1);
    end

    // Reset in the middle of a walk, while step 5 is presented.
    is_cw = 1'b0; start_x = 8'sd4; start_y = 8'sd0; r = 8'sd4; num_steps = 11'd8;
    step_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!step_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("midrst_valid_seen", int'(step_valid), 1);
    repeat (4) tick();
    check("midrst_step5_cur_x", int'(cur_x), 3);
    check("midrst_step5_cur_y", int'(cur_y), 3);
    check("midrst_step5_valid", int'(step_valid), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    step_ready = 1'b0;
    check("midrst_valid", int'(step_valid), 0);
    check("midrst_rdy", int'(rdy), 1);
    check("midrst_cur_x", int'(cur_x), 0);
    check("midrst_cur_y", int'(cur_y), 0);
    check("midrst_step_x", dir2int(step_x), 0);
    check("midrst_done", int'(done), 0);
    tick();
    run_job(vecs[0]);
    for (int k = 0; k < 8; k++) check("post_rst_seq", step_log[k], exp_seq[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
